apb_slave_mem: RTL

//   Parametrised APB3/APB4 slave backed by a word-addressed register-array memory.

---
 rtl/apb_slave_mem.sv | 124 ++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : APB3/APB4 slave backed by a word-addressed register memory with
//               programmable read/write wait states and PSLVERR on out-of-range
//               words. Define APB_MEM_PSTRB_EN to add per-byte write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int WR_WAIT = 1,
  parameter int RD_WAIT = 0
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int          c_BYTES   = DATA_W / 8;
  localparam int          c_LSB     = $clog2(c_BYTES);
  localparam int          c_WIDX_W  = ADDR_W - c_LSB;
  localparam int          c_MIDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] c_DEPTH   = 32'(DEPTH);
  localparam logic [2:0]  c_WR_WAIT = 3'(WR_WAIT);
  localparam logic [2:0]  c_RD_WAIT = 3'(RD_WAIT);

  localparam logic [0:0]  c_IDLE    = 1'b0;
  localparam logic [0:0]  c_ACCESS  = 1'b1;

  logic [0:0]          r_state;
  logic [2:0]          r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [c_WIDX_W-1:0] w_widx;
  logic [c_MIDX_W-1:0] w_midx;
  logic [c_BYTES-1:0]  w_strb;
  logic                w_oor;
  logic                w_access;
  logic                w_ready;
  logic                w_we;

  assign w_widx   = paddr[ADDR_W-1:c_LSB];
  assign w_midx   = w_widx[c_MIDX_W-1:0];
  assign w_oor    = (32'(w_widx) >= c_DEPTH);
  assign w_access = (r_state == c_ACCESS);
  assign w_ready  = (r_cnt == 3'd0);
  // Commit only on the edge that ends the completing access cycle.
  assign w_we     = w_access & psel & penable & w_ready & pwrite & ~w_oor;

`ifdef APB_MEM_PSTRB_EN
  assign w_strb = pstrb;
`else
  assign w_strb = '1;
`endif

  // Byte-offset address bits select nothing; there is no alignment error.
  generate
    if (c_LSB > 0) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^paddr[c_LSB-1:0];
    end
  endgenerate

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (psel && !penable) begin
            r_state <= c_ACCESS;
            r_cnt   <= pwrite ? c_WR_WAIT : c_RD_WAIT;
          end
        end
        c_ACCESS: begin
          if (!psel) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
          end else if (!penable) begin
            r_cnt   <= pwrite ? c_WR_WAIT : c_RD_WAIT;
          end else if (!w_ready) begin
            r_cnt   <= r_cnt - 3'd1;
          end else begin
            // Completion: a following setup phase is picked up from IDLE.
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (w_we) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (w_strb[b]) begin
          r_mem[w_midx][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
    end
  end

  assign pready  = w_ready;
  assign pslverr = w_access & w_ready & w_oor;
  assign prdata  = (w_access && w_ready && !pwrite && !w_oor) ? r_mem[w_midx] : '0;

endmodule
`default_nettype wire
